// File: rtl/count4_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : count4_down_timer
//  Description : Loadable down-counter with terminal-count detection and a
//                one-shot / auto-reload mode selected on the terminal cycle.
//                A three-state FSM (IDLE / RUN / DONE) tracks activity.
//
//  Ports
//    clk     in   1      clock, all state changes on the rising edge
//    clr_n   in   1      asynchronous active-low clear
//    enable  in   1      count-down qualifier
//    load    in   1      synchronous load strobe (priority over enable)
//    din     in   WIDTH  start value, also captured as the reload value
//    reload  in   1      1 = auto-reload, 0 = one-shot (sampled at tc)
//    count   out  WIDTH  current counter value (registered)
//    tc      out  1      terminal count (combinational)
//    busy    out  1      FSM is in RUN
//    done    out  1      FSM is in DONE
//
//  Revision    : 1.0  initial release
// ============================================================================
module count4_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload_val;
    logic [WIDTH-1:0] w_reload_val_nxt;
    logic             w_tc;

    // Terminal cycle: an enabled RUN cycle sitting at zero. A simultaneous
    // load wins and suppresses the pulse.
    assign w_tc = (r_state == ST_RUN) && enable && (r_count == C_ZERO) && !load;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= ST_IDLE;
            r_count      <= C_ZERO;
            r_reload_val <= C_ZERO;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_reload_val <= w_reload_val_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_reload_val_nxt = r_reload_val;

        if (load) begin
            w_count_nxt      = din;
            w_reload_val_nxt = din;
            w_state_nxt      = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (enable) begin
                        if (r_count == C_ZERO) begin
                            // Zero never wraps: either restart the period or
                            // park at zero in DONE.
                            if (reload) begin
                                w_count_nxt = r_reload_val;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_count_nxt = r_count - C_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_count_nxt = C_ZERO;
                end
                default: begin
                    // IDLE holds everything until a load arrives.
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign count = r_count;
    assign tc    = w_tc;
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_count4_down_timer.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_count4_down_timer
//  Description : Self-checking bench for count4_down_timer; compares the DUT
//                against a behavioural model of the timer rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count4_down_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clr_n;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    int n_vec;
    int n_err;

    // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
    int m_mode;
    int m_count;
    int m_rel;

    logic exp_tc;
    logic obs_tc;

    count4_down_timer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .enable (enable),
        .load   (load),
        .din    (din),
        .reload (reload),
        .count  (count),
        .tc     (tc),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode  = 0;
        m_count = 0;
        m_rel   = 0;
    endtask

    // Drive one cycle's inputs at the falling edge, sample tc before the
    // rising edge, advance the model, and leave time at posedge+1.
    task automatic drive_cycle(input logic en, input logic ld,
                               input int d, input logic rl);
        @(negedge clk);
        enable = en;
        load   = ld;
        din    = WIDTH'(d);
        reload = rl;
        #1;
        exp_tc = (m_mode == 1) && en && (m_count == 0) && !ld;
        obs_tc = tc;
        @(posedge clk);
        if (ld) begin
            m_count = d;
            m_rel   = d;
            m_mode  = 1;
        end else if (m_mode == 1 && en) begin
            if (m_count == 0) begin
                if (rl) m_count = m_rel;
                else    m_mode  = 2;
            end else begin
                m_count = m_count - 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        // While clear is held, everything reads zero regardless of enable.
        #5;
        n_vec++;
        if ({count, busy, done, tc} !== {4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_t5: got count=%0d busy=%b done=%b tc=%b, want 0 0 0 0",
                     count, busy, done, tc);
        end
        repeat (2) begin
            @(negedge clk);
            enable = ~enable;
            #1;
            n_vec++;
            if ({count, busy, done, tc} !== {4'd0, 3'b000}) begin
                n_err++;
                $display("FAIL reset_held: got count=%0d busy=%b done=%b tc=%b, want 0 0 0 0",
                         count, busy, done, tc);
            end
        end
        #4;
        clr_n = 1'b1;
        model_reset();
        // No load after release: IDLE must ignore enable.
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 15), 1'b0);
            n_vec++;
            if ({obs_tc, count, busy, done} !== {1'b0, 4'd0, 2'b00}) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got tc=%b count=%0d busy=%b done=%b, want 0 0 0 0",
                         i, obs_tc, count, busy, done);
            end
        end
        // Release clear shortly before an edge that carries a load.
        @(negedge clk);
        clr_n  = 1'b0;
        enable = 1'b0;
        #3;
        load  = 1'b1;
        din   = 4'd6;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        m_mode = 1; m_count = 6; m_rel = 6;
        n_vec++;
        if ({count, busy} !== {4'd6, 1'b1}) begin
            n_err++;
            $display("FAIL reset_first_edge_load: got count=%0d busy=%b, want 6 1", count, busy);
        end
    endtask

    task automatic test_oneshot();
        int exp_seq [5] = '{3, 2, 1, 0, 0};
        int tc_seen = 0;
        drive_cycle(1'b1, 1'b1, 3, 1'b0);
        n_vec++;
        if ({count, busy} !== {4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL oneshot_load: got count=%0d busy=%b, want 3 1", count, busy);
        end
        for (int i = 1; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 0, 1'b0);
            if (obs_tc) tc_seen++;
            n_vec++;
            if ({obs_tc, count, busy, done} !== {exp_tc, WIDTH'(m_count), m_mode == 1, m_mode == 2}
                || (i < 5 && count !== WIDTH'(exp_seq[i]))) begin
                n_err++;
                $display("FAIL oneshot[%0d]: got tc=%b count=%0d busy=%b done=%b, want %b %0d %b %b",
                         i, obs_tc, count, busy, done, exp_tc, m_count, m_mode == 1, m_mode == 2);
            end
        end
        n_vec++;
        if (tc_seen != 1 || done !== 1'b1 || count !== 4'd0) begin
            n_err++;
            $display("FAIL oneshot_final: got tc_pulses=%0d done=%b count=%0d, want 1 1 0",
                     tc_seen, done, count);
        end
    endtask

    task automatic test_autoreload_gaps();
        int tc_seen = 0;
        drive_cycle(1'b0, 1'b1, 2, 1'b1);
        for (int i = 0; i < 25; i++) begin
            drive_cycle(i >= 5, 1'b0, 0, 1'b1);
            if (obs_tc) tc_seen++;
            n_vec++;
            if ({obs_tc, count, busy, done} !== {exp_tc, WIDTH'(m_count), 1'b1, 1'b0}
                || (i < 5 && count !== 4'd2)) begin
                n_err++;
                $display("FAIL autoreload[%0d]: got tc=%b count=%0d busy=%b done=%b, want %b %0d 1 0",
                         i, obs_tc, count, busy, done, exp_tc, m_count);
            end
        end
        // 20 enabled cycles with period 3 -> tc on enabled cycles 3,6,..,18.
        n_vec++;
        if (tc_seen != 6) begin
            n_err++;
            $display("FAIL autoreload_tc_count: got %0d pulses, want 6", tc_seen);
        end
    endtask

    task automatic test_collision();
        drive_cycle(1'b0, 1'b1, 0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5, 1'b0);
        n_vec++;
        if ({obs_tc, count, busy, done} !== {1'b0, 4'd5, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL collision: got tc=%b count=%0d busy=%b done=%b, want 0 5 1 0",
                     obs_tc, count, busy, done);
        end
    endtask

    task automatic test_edge_values();
        int cycles = 0;
        drive_cycle(1'b1, 1'b1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 0, 1'b1);
            n_vec++;
            if ({obs_tc, count, busy} !== {1'b1, 4'd0, 1'b1}) begin
                n_err++;
                $display("FAIL edge_zero_reload[%0d]: got tc=%b count=%0d busy=%b, want 1 0 1",
                         i, obs_tc, count, busy);
            end
        end
        drive_cycle(1'b1, 1'b1, 15, 1'b0);
        while (done !== 1'b1 && cycles < 40) begin
            drive_cycle(1'b1, 1'b0, 0, 1'b0);
            cycles++;
            n_vec++;
            if ({obs_tc, count, busy, done} !== {exp_tc, WIDTH'(m_count), m_mode == 1, m_mode == 2}) begin
                n_err++;
                $display("FAIL edge_max[%0d]: got tc=%b count=%0d busy=%b done=%b, want %b %0d %b %b",
                         cycles, obs_tc, count, busy, done, exp_tc, m_count, m_mode == 1, m_mode == 2);
            end
        end
        n_vec++;
        if (cycles != 16) begin
            n_err++;
            $display("FAIL edge_max_len: got done after %0d cycles, want 16", cycles);
        end
        // DONE ignores enable.
        drive_cycle(1'b1, 1'b0, 0, 1'b1);
        n_vec++;
        if ({obs_tc, count, done} !== {1'b0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL done_hold: got tc=%b count=%0d done=%b, want 0 0 1", obs_tc, count, done);
        end
    endtask

    task automatic test_midrun_reset();
        drive_cycle(1'b1, 1'b1, 9, 1'b1);
        drive_cycle(1'b1, 1'b0, 0, 1'b1);
        drive_cycle(1'b1, 1'b0, 0, 1'b1);
        n_vec++;
        if (count !== 4'd7) begin
            n_err++;
            $display("FAIL midrun_pre: got count=%0d, want 7", count);
        end
        clr_n = 1'b0;
        #1;
        n_vec++;
        if ({count, busy, tc} !== {4'd0, 2'b00}) begin
            n_err++;
            $display("FAIL midrun_async: got count=%0d busy=%b tc=%b, want 0 0 0", count, busy, tc);
        end
        #2;
        clr_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 0, 1'b1);
            n_vec++;
            if ({obs_tc, count, busy, done} !== {1'b0, 4'd0, 2'b00}) begin
                n_err++;
                $display("FAIL midrun_idle[%0d]: got tc=%b count=%0d busy=%b done=%b, want 0 0 0 0",
                         i, obs_tc, count, busy, done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                        $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            n_vec++;
            if ({obs_tc, count, busy, done} !== {exp_tc, WIDTH'(m_count), m_mode == 1, m_mode == 2}) begin
                n_err++;
                $display("FAIL random[%0d]: got tc=%b count=%0d busy=%b done=%b, want %b %0d %b %b",
                         i, obs_tc, count, busy, done, exp_tc, m_count, m_mode == 1, m_mode == 2);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        clr_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        din    = '0;
        reload = 1'b0;
        model_reset();
        test_reset();
        test_oneshot();
        test_autoreload_gaps();
        test_collision();
        test_edge_values();
        test_midrun_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
